// File: rtl/aes_xact_sequencer_if.sv
// Host stream, response stream, key-expander and cipher bus of the AES transactor.
// slave is the sequencer's view; master is the host / AES-core side.
interface aes_xact_sequencer_if #(
  parameter int DATA_W = 128,
  parameter int KEY_W  = 256,
  parameter int TAG_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [1:0]        cmd_key_mode;
  logic [KEY_W-1:0]  cmd_data;
  logic [TAG_W-1:0]  cmd_tag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic [1:0]        rsp_status;

  logic [KEY_W-1:0]  key_i_key;
  logic [1:0]        key_i_key_mode;
  logic              key_i_start;
  logic              key_o_key_ready;

  logic [DATA_W-1:0] cph_i_data;
  logic              cph_i_data_valid;
  logic              cph_i_ende;
  logic              cph_i_enable;
  logic              cph_o_ready;
  logic [DATA_W-1:0] cph_o_data;
  logic              cph_o_data_valid;

  logic              busy;
  logic              key_loaded;

  modport slave (
    input  cmd_valid, cmd_op, cmd_key_mode, cmd_data, cmd_tag,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_tag, rsp_status,
    input  rsp_ready,
    output key_i_key, key_i_key_mode, key_i_start,
    input  key_o_key_ready,
    output cph_i_data, cph_i_data_valid, cph_i_ende, cph_i_enable,
    input  cph_o_ready, cph_o_data, cph_o_data_valid,
    output busy, key_loaded
  );

  modport master (
    output cmd_valid, cmd_op, cmd_key_mode, cmd_data, cmd_tag,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_tag, rsp_status,
    output rsp_ready,
    input  key_i_key, key_i_key_mode, key_i_start,
    output key_o_key_ready,
    input  cph_i_data, cph_i_data_valid, cph_i_ende, cph_i_enable,
    output cph_o_ready, cph_o_data, cph_o_data_valid,
    input  busy, key_loaded
  );
endinterface

// File: rtl/aes_xact_sequencer.sv
// Hardware AES transactor: queues tagged key/encrypt/decrypt commands, drives
// the key-expansion and cipher handshakes, and returns one response per command.
//
// state        | meaning
// IDLE         | wait for a queued command and a free response slot
// DECODE       | route the working command
// KEY_START    | one-cycle key_i_start pulse
// KEY_WAIT     | wait for key_o_key_ready (ignored in the first cycle)
// CPH_WAIT_RDY | wait for cph_o_ready
// CPH_ISSUE    | one-cycle cph_i_data_valid strobe
// CPH_WAIT     | wait for cph_o_data_valid (ignored in the first cycle)
// RESP         | push the response, back to IDLE
module aes_xact_sequencer #(
  parameter int DATA_W    = 128,
  parameter int KEY_W     = 256,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  aes_xact_sequencer_if.slave  bus
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int CEW = 4 + KEY_W + TAG_W;
  localparam int REW = DATA_W + TAG_W + 2;
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_KEY = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;
  localparam logic [1:0] MODE_BAD = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_NO_KEY  = 2'b10;
  localparam logic [1:0] ST_BAD_CMD = 2'b11;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_KEY_START,
    S_KEY_WAIT,
    S_CPH_WAIT_RDY,
    S_CPH_ISSUE,
    S_CPH_WAIT,
    S_RESP
  } state_t;

  state_t state;

  // command FIFO
  logic [CEW-1:0] cmd_mem [CMD_DEPTH];
  logic [CAW-1:0] cmd_wr_ptr, cmd_rd_ptr;
  logic [CAW:0]   cmd_count;
  logic           cmd_empty, cmd_full, cmd_push, cmd_pop;

  // response FIFO
  logic [REW-1:0] rsp_mem [RSP_DEPTH];
  logic [RAW-1:0] rsp_wr_ptr, rsp_rd_ptr;
  logic [RAW:0]   rsp_count;
  logic           rsp_empty, rsp_full, rsp_push, rsp_pop;

  // working command and result
  logic [1:0]        w_op, w_mode;
  logic [KEY_W-1:0]  w_data;
  logic [TAG_W-1:0]  w_tag;
  logic [DATA_W-1:0] res_data;
  logic [1:0]        res_status;
  logic [TW-1:0]     tmo_cnt;

  assign cmd_empty = (cmd_count == '0);
  assign cmd_full  = (cmd_count == (CAW+1)'(CMD_DEPTH));
  assign rsp_empty = (rsp_count == '0);
  assign rsp_full  = (rsp_count == (RAW+1)'(RSP_DEPTH));

  assign cmd_push = bus.cmd_valid && !cmd_full;
  // Dispatch only with a free response slot, so RESP can always push.
  assign cmd_pop  = (state == S_IDLE) && !cmd_empty && !rsp_full;
  assign rsp_push = (state == S_RESP);
  assign rsp_pop  = !rsp_empty && bus.rsp_ready;

  assign bus.cmd_ready  = !cmd_full;
  assign bus.rsp_valid  = !rsp_empty;
  assign bus.rsp_data   = rsp_empty ? '0 : rsp_mem[rsp_rd_ptr][REW-1 -: DATA_W];
  assign bus.rsp_tag    = rsp_empty ? '0 : rsp_mem[rsp_rd_ptr][TAG_W+1:2];
  assign bus.rsp_status = rsp_empty ? '0 : rsp_mem[rsp_rd_ptr][1:0];
  assign bus.busy       = (state != S_IDLE) || !cmd_empty;

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wr_ptr] <= {bus.cmd_op, bus.cmd_key_mode, bus.cmd_data, bus.cmd_tag};
    if (rsp_push) rsp_mem[rsp_wr_ptr] <= {res_data, w_tag, res_status};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_count  <= '0;
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_count  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_count <= cmd_count + 1'b1;
        2'b01:   cmd_count <= cmd_count - 1'b1;
        default: cmd_count <= cmd_count;
      endcase
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_count <= rsp_count + 1'b1;
        2'b01:   rsp_count <= rsp_count - 1'b1;
        default: rsp_count <= rsp_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= S_IDLE;
      w_op                 <= '0;
      w_mode               <= '0;
      w_data               <= '0;
      w_tag                <= '0;
      res_data             <= '0;
      res_status           <= ST_OK;
      tmo_cnt              <= '0;
      bus.key_i_key        <= '0;
      bus.key_i_key_mode   <= '0;
      bus.key_i_start      <= 1'b0;
      bus.cph_i_data       <= '0;
      bus.cph_i_data_valid <= 1'b0;
      bus.cph_i_ende       <= 1'b0;
      bus.cph_i_enable     <= 1'b0;
      bus.key_loaded       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_pop) begin
            {w_op, w_mode, w_data, w_tag} <= cmd_mem[cmd_rd_ptr];
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          res_data <= '0;
          if (w_op == OP_RSV || (w_op == OP_KEY && w_mode == MODE_BAD)) begin
            res_status <= ST_BAD_CMD;
            state      <= S_RESP;
          end else if (w_op == OP_KEY) begin
            bus.key_i_key      <= w_data;
            bus.key_i_key_mode <= w_mode;
            bus.key_i_start    <= 1'b1;
            bus.key_loaded     <= 1'b0;
            state              <= S_KEY_START;
          end else if (!bus.key_loaded) begin
            res_status <= ST_NO_KEY;
            state      <= S_RESP;
          end else if (bus.cph_o_ready) begin
            // Ready already high: skip the wait state to issue in the next cycle.
            bus.cph_i_data       <= w_data[DATA_W-1:0];
            bus.cph_i_data_valid <= 1'b1;
            bus.cph_i_ende       <= (w_op == OP_DEC);
            bus.cph_i_enable     <= 1'b1;
            state                <= S_CPH_ISSUE;
          end else begin
            tmo_cnt <= '0;
            state   <= S_CPH_WAIT_RDY;
          end
        end

        S_KEY_START: begin
          bus.key_i_start <= 1'b0;
          tmo_cnt         <= '0;
          state           <= S_KEY_WAIT;
        end

        S_KEY_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (tmo_cnt != '0 && bus.key_o_key_ready) begin
            bus.key_loaded <= 1'b1;
            res_status     <= ST_OK;
            state          <= S_RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            res_status <= ST_TIMEOUT;
            state      <= S_RESP;
          end
        end

        S_CPH_WAIT_RDY: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (bus.cph_o_ready) begin
            bus.cph_i_data       <= w_data[DATA_W-1:0];
            bus.cph_i_data_valid <= 1'b1;
            bus.cph_i_ende       <= (w_op == OP_DEC);
            bus.cph_i_enable     <= 1'b1;
            state                <= S_CPH_ISSUE;
          end else if (tmo_cnt == TMO_LAST) begin
            res_status <= ST_TIMEOUT;
            state      <= S_RESP;
          end
        end

        S_CPH_ISSUE: begin
          bus.cph_i_data_valid <= 1'b0;
          tmo_cnt              <= '0;
          state                <= S_CPH_WAIT;
        end

        S_CPH_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (tmo_cnt != '0 && bus.cph_o_data_valid) begin
            res_data         <= bus.cph_o_data;
            res_status       <= ST_OK;
            bus.cph_i_enable <= 1'b0;
            state            <= S_RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            res_data         <= '0;
            res_status       <= ST_TIMEOUT;
            bus.cph_i_enable <= 1'b0;
            state            <= S_RESP;
          end
        end

        S_RESP: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_xact_sequencer.sv
// Directed bench for aes_xact_sequencer with behavioural key-expander and cipher models.
module tb_aes_xact_sequencer;

  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_xact_sequencer_if #(.DATA_W(128), .KEY_W(256), .TAG_W(4)) bus ();

  aes_xact_sequencer #(
    .DATA_W(128), .KEY_W(256), .CMD_DEPTH(4), .RSP_DEPTH(4), .TAG_W(4), .TIMEOUT(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // monitors
  int           ks_count = 0, ks_cyc = 0;
  logic [255:0] ks_key;
  logic [1:0]   ks_mode;
  int           dv_count = 0, dv_cyc = 0;
  logic         dv_ende;
  logic [127:0] dv_data;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.key_i_start) begin
      ks_count++;
      ks_cyc  = cyc;
      ks_key  = bus.key_i_key;
      ks_mode = bus.key_i_key_mode;
    end
    if (bus.cph_i_data_valid) begin
      dv_count++;
      dv_cyc  = cyc;
      dv_ende = bus.cph_i_ende;
      dv_data = bus.cph_i_data;
    end
  end

  // key expander: ready pulse 10 cycles after start
  logic key_rdy = 1'b0;
  logic key_hang = 1'b0;
  assign bus.key_o_key_ready = key_rdy;
  always @(negedge clk) begin
    if (bus.key_i_start && !key_hang) begin
      repeat (10) @(negedge clk);
      key_rdy = 1'b1;
      @(negedge clk);
      key_rdy = 1'b0;
    end
  end

  // cipher: knows one PT/CT pair, inverts anything else
  logic         cph_dv = 1'b0;
  logic [127:0] cph_res = '0;
  logic         cph_hang = 1'b0;
  assign bus.cph_o_data_valid = cph_dv;
  assign bus.cph_o_data       = cph_res;
  always @(negedge clk) begin
    if (bus.cph_i_data_valid && !cph_hang) begin
      logic [127:0] r;
      if (!bus.cph_i_ende && bus.cph_i_data == PT)     r = CT;
      else if (bus.cph_i_ende && bus.cph_i_data == CT) r = PT;
      else                                              r = ~bus.cph_i_data;
      repeat (4) @(negedge clk);
      cph_res = r;
      cph_dv  = 1'b1;
      @(negedge clk);
      cph_dv  = 1'b0;
    end
  end

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  int acc_cyc;
  task automatic send_cmd(input logic [1:0] op, input logic [1:0] mode,
                          input logic [255:0] data, input logic [3:0] tag);
    int n = 0;
    bus.cmd_valid    = 1'b1;
    bus.cmd_op       = op;
    bus.cmd_key_mode = mode;
    bus.cmd_data     = data;
    bus.cmd_tag      = tag;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept_wait", n < 200, 1);
    acc_cyc = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  logic [3:0]   r_tag;
  logic [1:0]   r_st;
  logic [127:0] r_data;
  int           r_cyc;
  task automatic get_rsp();
    int n = 0;
    while (!bus.rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("rsp_wait", n < 400, 1);
    r_tag  = bus.rsp_tag;
    r_st   = bus.rsp_status;
    r_data = bus.rsp_data;
    r_cyc  = cyc;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic expect_rsp(input string name, input logic [3:0] tag,
                            input logic [1:0] st, input logic [127:0] data);
    get_rsp();
    check({name, "_tag"}, r_tag, tag);
    check({name, "_status"}, r_st, st);
    check({name, "_data"}, r_data, data);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", n < 400, 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_cmd_ready"}, bus.cmd_ready, 1);
    check({name, "_rsp_valid"}, bus.rsp_valid, 0);
    check({name, "_busy"}, bus.busy, 0);
    check({name, "_key_loaded"}, bus.key_loaded, 0);
    check({name, "_key_start"}, bus.key_i_start, 0);
    check({name, "_key_key"}, bus.key_i_key, 0);
    check({name, "_cph_dv"}, bus.cph_i_data_valid, 0);
    check({name, "_cph_en"}, bus.cph_i_enable, 0);
    check({name, "_cph_data"}, bus.cph_i_data, 0);
    check({name, "_rsp_data"}, bus.rsp_data, 0);
  endtask

  initial begin
    int ks0, dv0, n;
    reset            = 1'b1;
    bus.cmd_valid    = 1'b0;
    bus.cmd_op       = '0;
    bus.cmd_key_mode = '0;
    bus.cmd_data     = '0;
    bus.cmd_tag      = '0;
    bus.rsp_ready    = 1'b0;
    bus.cph_o_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // ENC with no key loaded, then a reserved opcode
    ks0 = ks_count;
    dv0 = dv_count;
    send_cmd(2'b01, 2'b00, {128'h0, PT}, 4'd3);
    expect_rsp("nokey", 4'd3, 2'b10, 128'h0);
    send_cmd(2'b11, 2'b00, 256'h0, 4'd4);
    expect_rsp("badop", 4'd4, 2'b11, 128'h0);
    send_cmd(2'b00, 2'b11, KEY, 4'd5);
    expect_rsp("badmode", 4'd5, 2'b11, 128'h0);
    check("nokey_no_cph", dv_count - dv0, 0);
    check("bad_no_key_start", ks_count - ks0, 0);
    wait_idle();

    // KEY load, 256-bit
    send_cmd(2'b00, 2'b10, KEY, 4'd1);
    expect_rsp("key", 4'd1, 2'b00, 128'h0);
    check("key_pulses", ks_count - ks0, 1);
    check("key_latency", ks_cyc - acc_cyc, 3);
    check("key_value", ks_key, KEY);
    check("key_mode", ks_mode, 2'b10);
    check("key_loaded", bus.key_loaded, 1);
    wait_idle();

    // ENC then DEC
    dv0 = dv_count;
    send_cmd(2'b01, 2'b00, {128'h0, PT}, 4'd2);
    expect_rsp("enc", 4'd2, 2'b00, CT);
    check("enc_pulses", dv_count - dv0, 1);
    check("enc_latency", dv_cyc - acc_cyc, 3);
    check("enc_ende", dv_ende, 0);
    check("enc_in", dv_data, PT);
    wait_idle();
    send_cmd(2'b10, 2'b00, {128'h0, CT}, 4'd6);
    expect_rsp("dec", 4'd6, 2'b00, PT);
    check("dec_ende", dv_ende, 1);
    check("dec_in", dv_data, CT);
    check("cph_en_off", bus.cph_i_enable, 0);
    wait_idle();

    // cipher timeout, with a second command queued behind it
    cph_hang = 1'b1;
    send_cmd(2'b01, 2'b00, {128'h0, PT}, 4'd7);
    send_cmd(2'b10, 2'b00, {128'h0, CT}, 4'd8);
    expect_rsp("tmo", 4'd7, 2'b01, 128'h0);
    cph_hang = 1'b0;
    check("tmo_latency", r_cyc - dv_cyc, 18);
    check("tmo_cph_en", bus.cph_i_enable, 0);
    expect_rsp("after_tmo", 4'd8, 2'b00, PT);
    wait_idle();

    // fill both FIFOs with rsp_ready low, then drain in order
    for (int i = 0; i < 8; i++) send_cmd(2'b11, 2'b00, 256'h0, 4'(i));
    repeat (10) @(negedge clk);
    check("fill_cmd_ready", bus.cmd_ready, 0);
    check("fill_rsp_valid", bus.rsp_valid, 1);
    check("fill_busy", bus.busy, 1);
    for (int i = 0; i < 8; i++) expect_rsp("drain", 4'(i), 2'b11, 128'h0);
    wait_idle();
    check("drain_empty", bus.rsp_valid, 0);

    // reset while waiting on the cipher with two commands queued
    cph_hang = 1'b1;
    dv0 = dv_count;
    send_cmd(2'b01, 2'b00, {128'h0, PT}, 4'd10);
    n = 0;
    while (dv_count == dv0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_issue_wait", n < 50, 1);
    send_cmd(2'b01, 2'b00, {128'h0, PT}, 4'd11);
    send_cmd(2'b10, 2'b00, {128'h0, CT}, 4'd12);
    check("pre_rst_cph_en", bus.cph_i_enable, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    dv0 = dv_count;
    repeat (30) @(negedge clk);
    check("post_rst_rsp", bus.rsp_valid, 0);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_cph", dv_count - dv0, 0);
    cph_hang = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
